entrada_handshake: RTL and testbench

Input-side responder for the processor's keyboard/switch input instruction. While the processor signals it is waiting for input, this block synchronizes and debounces the raw enter button and the 8 data switches. On a clean button press it captures the switch value and holds the enter acknowledge high. It then completes a four-phase handshake with the processor, and a held button never produces a second entry. It sits between the board pins and the processor's `dadosIN`/`chave` inputs.

---
 rtl/entrada_handshake.sv | 138 +++++++++++++
 tb/tb_entrada_handshake.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/entrada_handshake.sv
// Debounced enter/switch capture for the processor input instruction, with a four-phase chave handshake.
// Capture lands DEBOUNCE_CYCLES+2 edges after btn_raw is first sampled high; chave holds until controleIN drops.
module entrada_handshake #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_raw,
  input  logic [DATA_W-1:0] sw_raw,
  input  logic              controleIN,
  output logic [DATA_W-1:0] dadosIN,
  output logic              chave,
  output logic              aguardando
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACK,
    S_RELEASE
  } state_t;

  logic              r_btn_s1;
  logic              r_btn_s2;
  logic [DATA_W-1:0] r_sw_s1;
  logic [DATA_W-1:0] r_sw_s2;
  logic              r_stable;
  logic              r_stable_d;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_lo_cnt;
  logic              r_need_release;
  state_t            r_state;
  logic              r_chave;
  logic              r_aguardando;
  logic [DATA_W-1:0] r_dados;

  state_t            w_state_nxt;
  logic              w_capture;
  logic              w_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw_raw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Any disagreeing run shorter than DEBOUNCE_CYCLES is forgotten on the next agreeing cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_stable_d <= r_stable;
      if (r_btn_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_btn_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Reset clears the debouncer, so a button held through reset would look like a fresh press;
  // presses stay masked until the button has been seen low for a full debounce window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_need_release <= 1'b1;
      r_lo_cnt       <= '0;
    end else if (r_btn_s2) begin
      r_lo_cnt <= '0;
    end else if (r_lo_cnt == CNT_LAST) begin
      r_need_release <= 1'b0;
    end else begin
      r_lo_cnt <= r_lo_cnt + CW'(1);
    end
  end

  assign w_press = r_stable & ~r_stable_d & ~r_need_release;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (controleIN) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!controleIN) begin
          w_state_nxt = S_IDLE;
        end else if (w_press) begin
          w_state_nxt = S_ACK;
          w_capture   = 1'b1;
        end
      end
      S_ACK: begin
        if (!controleIN) w_state_nxt = r_stable ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        if (!r_stable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_chave      <= 1'b0;
      r_aguardando <= 1'b0;
      r_dados      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_chave      <= (w_state_nxt == S_ACK);
      r_aguardando <= (w_state_nxt == S_ARMED);
      if (w_capture) r_dados <= r_sw_s2;
    end
  end

  assign dadosIN    = r_dados;
  assign chave      = r_chave;
  assign aguardando = r_aguardando;

endmodule

// File: tb/tb_entrada_handshake.sv
// Directed bench for entrada_handshake with DEBOUNCE_CYCLES=4: vector table for reset and a clean entry,
// then hand-written sequences for bounce, held button, withdrawal and reset during ACK.
module tb_entrada_handshake;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic [7:0] sw_raw;
  logic       controleIN;
  logic [7:0] dadosIN;
  logic       chave;
  logic       aguardando;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic       btn;
    logic [7:0] sw;
    logic       ctl;
    logic       e_chave;
    logic [7:0] e_dados;
    logic       e_agu;
  } vec_t;

  vec_t vq[$];

  entrada_handshake #(.DEBOUNCE_CYCLES(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .controleIN (controleIN),
    .dadosIN    (dadosIN),
    .chave      (chave),
    .aguardando (aguardando)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic b, input logic [7:0] s, input logic c,
                     input logic ec, input logic [7:0] ed, input logic ea, input int n);
    vec_t v;
    v.rst = r; v.btn = b; v.sw = s; v.ctl = c;
    v.e_chave = ec; v.e_dados = ed; v.e_agu = ea;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string nm, input logic ec, input logic [7:0] ed, input logic ea);
    n_checks++;
    if ({chave, dadosIN, aguardando} !== {ec, ed, ea}) begin
      n_errors++;
      $display("FAIL %s: got chave=%0b dadosIN=%h aguardando=%0b, want chave=%0b dadosIN=%h aguardando=%0b",
               nm, chave, dadosIN, aguardando, ec, ed, ea);
    end
  endtask

  initial begin
    int first_hi;
    int rises;
    logic prev;

    // rst btn sw ctl | chave dados agu | repeat
    add(1, 1, 8'hFF, 0, 0, 8'h00, 0, 2);  // reset with button and switches high
    add(0, 0, 8'hFF, 0, 0, 8'h00, 0, 4);  // button low long enough to unmask presses
    add(0, 0, 8'hA5, 1, 0, 8'h00, 1, 2);  // request -> ARMED
    add(0, 1, 8'hA5, 1, 0, 8'h00, 1, 6);  // edges 0..5 of the press
    add(0, 1, 8'hA5, 1, 1, 8'hA5, 0, 3);  // capture at edge 6, chave held
    add(0, 1, 8'hA5, 0, 0, 8'hA5, 0, 1);  // request dropped -> chave falls, RELEASE
    add(0, 1, 8'hA5, 1, 0, 8'hA5, 0, 1);  // RELEASE ignores a new request
    add(0, 0, 8'hA5, 1, 0, 8'hA5, 0, 7);  // button released, stable falls, IDLE at L0+6
    add(0, 0, 8'hA5, 1, 0, 8'hA5, 1, 1);  // re-armed one edge later

    rst = vq[0].rst; btn_raw = vq[0].btn; sw_raw = vq[0].sw; controleIN = vq[0].ctl;
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; btn_raw = vq[i].btn; sw_raw = vq[i].sw; controleIN = vq[i].ctl;
      tick();
      expect3($sformatf("vec%0d", i), vq[i].e_chave, vq[i].e_dados, vq[i].e_agu);
    end

    // Bounce: high 3, low 1, high 2, low -- never a full debounce window
    sw_raw = 8'h5A;
    for (int i = 0; i < 12; i++) begin
      btn_raw = (i < 3) || (i == 4) || (i == 5);
      tick();
      expect3($sformatf("bounce%0d", i), 1'b0, 8'hA5, 1'b1);
    end
    btn_raw = 1'b1;
    first_hi = -1; rises = 0; prev = chave;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (chave && !prev) rises++;
      if (chave && first_hi < 0) first_hi = i;
      prev = chave;
    end
    n_checks++;
    if (rises != 1) begin
      n_errors++;
      $display("FAIL bounce_one_capture: got %0d captures, want 1", rises);
    end
    n_checks++;
    if (first_hi != 7) begin
      n_errors++;
      $display("FAIL press_latency: chave rose at tick %0d, want 7", first_hi);
    end
    expect3("bounce_capture", 1'b1, 8'h5A, 1'b0);
    controleIN = 1'b0; tick();
    expect3("bounce_drop", 1'b0, 8'h5A, 1'b0);
    btn_raw = 1'b0;
    repeat (10) tick();
    expect3("bounce_idle", 1'b0, 8'h5A, 1'b0);

    // Held button: stable-high before the request never captures
    btn_raw = 1'b1;
    repeat (10) tick();
    controleIN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect3($sformatf("held%0d", i), 1'b0, 8'h5A, 1'b1);
    end
    btn_raw = 1'b0;
    repeat (10) tick();
    sw_raw = 8'h3C; btn_raw = 1'b1;
    repeat (6) tick();
    expect3("repress_edge5", 1'b0, 8'h5A, 1'b1);
    tick();
    expect3("repress_capture", 1'b1, 8'h3C, 1'b0);
    controleIN = 1'b0; tick();
    btn_raw = 1'b0;
    repeat (10) tick();
    expect3("repress_idle", 1'b0, 8'h3C, 1'b0);

    // Withdrawal in the same cycle as press
    controleIN = 1'b1;
    repeat (2) tick();
    expect3("wd_armed", 1'b0, 8'h3C, 1'b1);
    sw_raw = 8'h77; btn_raw = 1'b1;
    repeat (6) tick();
    controleIN = 1'b0; tick();
    expect3("wd_edge6", 1'b0, 8'h3C, 1'b0);
    tick();
    expect3("wd_after", 1'b0, 8'h3C, 1'b0);
    controleIN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect3($sformatf("wd_rearm%0d", i), 1'b0, 8'h3C, 1'b1);
    end

    // Reset in the middle of ACK
    btn_raw = 1'b0; controleIN = 1'b0;
    repeat (10) tick();
    controleIN = 1'b1;
    repeat (2) tick();
    sw_raw = 8'hC3; btn_raw = 1'b1;
    repeat (7) tick();
    expect3("rack_capture", 1'b1, 8'hC3, 1'b0);
    rst = 1'b1; tick();
    rst = 1'b0;
    expect3("rack_reset", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      expect3($sformatf("rack_held%0d", i), 1'b0, 8'h00, 1'b1);
    end
    btn_raw = 1'b0;
    repeat (10) tick();
    btn_raw = 1'b1;
    repeat (7) tick();
    expect3("rack_repress", 1'b1, 8'hC3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
